// File: rtl/coco_keymatrix_if.sv
// Keyboard-matrix bundle between the PS/2 event source / PIA and the key matrix block.
// The master drives key events and column strobes; the slave returns row sense and matrix state.
interface coco_keymatrix_if;
    logic [10:0] ps2_key;
    logic [7:0]  col_strobe;
    logic [6:0]  row_out;
    logic [55:0] key_down;
    logic        any_key;

    modport master (
        output ps2_key,
        output col_strobe,
        input  row_out,
        input  key_down,
        input  any_key
    );

    modport slave (
        input  ps2_key,
        input  col_strobe,
        output row_out,
        output key_down,
        output any_key
    );
endinterface

// File: rtl/coco_keymatrix.sv
// PS/2 set-2 key events to CoCo 7x8 keyboard matrix, with short-press stretching so
// BASIC's polling scan still sees quick taps.
module coco_keymatrix #(
    parameter int HOLD_MIN = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    coco_keymatrix_if.slave  kbd
);
    // A zero hold still needs a 1-bit counter; it simply never leaves zero.
    localparam int CNT_W = (HOLD_MIN > 0) ? $clog2(HOLD_MIN + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_MIN);
    localparam logic [5:0] NO_KEY = 6'h3F;

    logic             toggle_prev_reg;
    logic             armed_reg;
    logic [54:0]      keys_reg, keys_next;
    logic             lshift_reg, lshift_next;
    logic             rshift_reg, rshift_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [5:0]       last_reg, last_next;
    logic             pending_reg, pending_next;
    logic [6:0]       row_out_reg;
    logic             any_key_reg;

    logic             ps2_event;
    logic             key_press;
    logic [8:0]       code_key;
    logic [5:0]       map_idx;
    logic             map_valid;
    logic             is_lshift;
    logic             is_rshift;
    logic [55:0]      key_down;
    logic [6:0]       row_hit;

    assign ps2_event = armed_reg && (kbd.ps2_key[10] != toggle_prev_reg);
    assign key_press = kbd.ps2_key[9];
    assign code_key  = kbd.ps2_key[8:0];
    assign is_lshift = (code_key == 9'h012);
    assign is_rshift = (code_key == 9'h059);

    // Scancode (with E0 flag as bit 8) to matrix index row*8+col.
    always_comb begin
        map_idx = NO_KEY;
        case (code_key)
            9'h054: map_idx = 6'd0;   9'h01C: map_idx = 6'd1;
            9'h032: map_idx = 6'd2;   9'h021: map_idx = 6'd3;
            9'h023: map_idx = 6'd4;   9'h024: map_idx = 6'd5;
            9'h02B: map_idx = 6'd6;   9'h034: map_idx = 6'd7;
            9'h033: map_idx = 6'd8;   9'h043: map_idx = 6'd9;
            9'h03B: map_idx = 6'd10;  9'h042: map_idx = 6'd11;
            9'h04B: map_idx = 6'd12;  9'h03A: map_idx = 6'd13;
            9'h031: map_idx = 6'd14;  9'h044: map_idx = 6'd15;
            9'h04D: map_idx = 6'd16;  9'h015: map_idx = 6'd17;
            9'h02D: map_idx = 6'd18;  9'h01B: map_idx = 6'd19;
            9'h02C: map_idx = 6'd20;  9'h03C: map_idx = 6'd21;
            9'h02A: map_idx = 6'd22;  9'h01D: map_idx = 6'd23;
            9'h022: map_idx = 6'd24;  9'h035: map_idx = 6'd25;
            9'h01A: map_idx = 6'd26;  9'h175: map_idx = 6'd27;
            9'h172: map_idx = 6'd28;  9'h16B: map_idx = 6'd29;
            9'h066: map_idx = 6'd29;  9'h174: map_idx = 6'd30;
            9'h029: map_idx = 6'd31;
            9'h045: map_idx = 6'd32;  9'h016: map_idx = 6'd33;
            9'h01E: map_idx = 6'd34;  9'h026: map_idx = 6'd35;
            9'h025: map_idx = 6'd36;  9'h02E: map_idx = 6'd37;
            9'h036: map_idx = 6'd38;  9'h03D: map_idx = 6'd39;
            9'h03E: map_idx = 6'd40;  9'h046: map_idx = 6'd41;
            9'h052: map_idx = 6'd42;  9'h04C: map_idx = 6'd43;
            9'h041: map_idx = 6'd44;  9'h04E: map_idx = 6'd45;
            9'h049: map_idx = 6'd46;  9'h04A: map_idx = 6'd47;
            9'h05A: map_idx = 6'd48;  9'h16C: map_idx = 6'd49;
            9'h076: map_idx = 6'd50;
            default: map_idx = NO_KEY;
        endcase
        map_valid = (map_idx != NO_KEY);
    end

    always_comb begin
        keys_next    = keys_reg;
        lshift_next  = lshift_reg;
        rshift_next  = rshift_reg;
        cnt_next     = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
        last_next    = last_reg;
        pending_next = pending_reg;

        // Hold time expired on a key whose release was deferred.
        if (pending_reg && cnt_reg == '0) begin
            keys_next[last_reg] = 1'b0;
            pending_next        = 1'b0;
        end

        if (ps2_event) begin
            if (is_lshift) begin
                lshift_next = key_press;
            end else if (is_rshift) begin
                rshift_next = key_press;
            end else if (map_valid) begin
                if (key_press) begin
                    if (map_idx == last_reg) begin
                        keys_next[map_idx] = 1'b1;
                        cnt_next           = HOLD_LOAD;
                        pending_next       = 1'b0;
                    end else if (!keys_reg[map_idx]) begin
                        if (pending_reg)
                            keys_next[last_reg] = 1'b0;
                        keys_next[map_idx] = 1'b1;
                        cnt_next           = HOLD_LOAD;
                        last_next          = map_idx;
                        pending_next       = 1'b0;
                    end
                end else begin
                    if (map_idx == last_reg && cnt_reg != '0 && keys_reg[map_idx])
                        pending_next = 1'b1;
                    else
                        keys_next[map_idx] = 1'b0;
                end
            end
        end
    end

    assign key_down = {lshift_reg | rshift_reg, keys_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_row
            assign row_hit[gi] = |(key_down[gi*8 +: 8] & ~kbd.col_strobe);
        end
    endgenerate

    // The tracker arms one clock after reset so a toggle bit already set is not an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toggle_prev_reg <= 1'b0;
            armed_reg       <= 1'b0;
            keys_reg        <= '0;
            lshift_reg      <= 1'b0;
            rshift_reg      <= 1'b0;
            cnt_reg         <= '0;
            last_reg        <= 6'd0;
            pending_reg     <= 1'b0;
            row_out_reg     <= 7'h7F;
            any_key_reg     <= 1'b0;
        end else begin
            toggle_prev_reg <= kbd.ps2_key[10];
            armed_reg       <= 1'b1;
            keys_reg        <= keys_next;
            lshift_reg      <= lshift_next;
            rshift_reg      <= rshift_next;
            cnt_reg         <= cnt_next;
            last_reg        <= last_next;
            pending_reg     <= pending_next;
            row_out_reg     <= ~row_hit;
            any_key_reg     <= |key_down;
        end
    end

    assign kbd.row_out  = row_out_reg;
    assign kbd.key_down = key_down;
    assign kbd.any_key  = any_key_reg;

endmodule

// File: doc/coco_keymatrix.md
Name: coco_keymatrix

Overview:
- Converts the 11-bit PS/2 key event stream from the HPS into the CoCo 7-row × 8-column keyboard matrix.
- The core's PIA scans this matrix: PIA port B drives the columns, and PIA port A reads the rows.
- Sits directly upstream of the PIA keyboard input inside the po8 core, replacing direct ps2_key consumption.
- Stretches very short keypresses so that BASIC's polling scan does not miss them.

Parameters:
HOLD_MIN, 1000000, minimum cycles a pressed key stays asserted after press (20 ms at 50 MHz); 0 disables stretching.

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
ps2_key  in  11  [10] toggle per event, [9] 1=press/0=release, [8] E0-extended, [7:0] set-2 scancode
col_strobe  in  8  PIA port B column drive, active-low
row_out  out  7  PIA port A row sense, active-low, registered
key_down  out  56  matrix state, bit = row*8+col, 1=pressed
any_key  out  1  OR of key_down, registered

Behaviour:
Reset (reset=0, async):
- key_down=0, row_out=7'h7F, any_key=0.
- hold counter=0, pending=0, lshift=0, rshift=0.
- toggle tracker loads from current ps2_key[10] on the first clk after reset release, so no spurious event is generated.

Event detect:
- An event occurs when ps2_key[10] differs from the registered previous value.
- At most one event per cycle; the event is decoded in the same cycle it is detected.

Map (extended flag must match; unmapped or mismatched codes are ignored, e.g. E0 12 is ignored):
- row0 cols0-7: @=54 A=1C B=32 C=21 D=23 E=24 F=2B G=34
- row1: H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44
- row2: P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D
- row3: X=22 Y=35 Z=1A UP=E0 75 DOWN=E0 72 LEFT=E0 6B or 66 RIGHT=E0 74 SPACE=29
- row4: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D
- row5: 8=3E 9=46 :=52 ;=4C ,=41 -=4E .=49 /=4A
- row6: ENTER=5A CLEAR=E0 6C BREAK=76, cols3-6 unused (always 0), SHIFT=col7
- Shift: 12 sets/clears lshift and 59 sets/clears rshift. key_down[55] = lshift|rshift. Shift events are never stretched.

Output:
- row_out[r] <= ~|(key_down[r*8+:8] & ~col_strobe), registered each cycle, 1-cycle latency from either input.
- any_key <= |key_down.

Stretch state (non-shift keys):
- Press of key k:
  - if pending: clear the pending key's bit in the same cycle;
  - set bit k; counter<=HOLD_MIN; last<=k; pending<=0.
- Release of k == last with counter!=0: pending<=1, bit k stays set.
- Release of k != last, or counter==0: clear bit k immediately.
- Counter decrements each cycle while nonzero.
- When counter reaches 0 with pending=1: clear bit last, pending<=0.
- Re-press of last while pending: pending<=0, counter reloads, bit remains set.
- Duplicate press (typematic repeat) of an already-set key: counter reloads only if k==last; no other effect.
- HOLD_MIN=0: releases are always immediate.
- Counter width is $clog2(HOLD_MIN+1); no wrap is possible.

Reset mid-operation: all state clears asynchronously; a pending release is dropped.

Test Plan:
1. Reset held low, then released; ps2_key toggle bit already 1 -> row_out=7F, key_down=0, no event decoded.
2. Press A (1C), col_strobe=FE -> key_down[1]... [A is row0 col1] key_down[1]=1; with col_strobe=FD, row_out=7E one cycle after col_strobe changes; with col_strobe=FE, row_out=7F.
3. HOLD_MIN=100: press Q, release 10 cycles later -> key_down[17] stays 1 until 100 cycles after the press, then 0; release 150 cycles after press -> clears on the next cycle.
4. HOLD_MIN=100: press B, release at +5, press C at +20 -> at +20 bit 2 clears and bit 3 sets in the same cycle.
5. Press 12, press 59, release 12 -> key_down[55] stays 1; release 59 -> key_down[55]=0 the next cycle; no stretch applied.
6. E0 75 press -> key_down[27]=1; plain 75 press -> ignored; E0 12 -> ignored; press Z, assert reset mid-hold -> key_down=0, row_out=7F immediately.
